// File: rtl/uart_tx_mmio_if.sv
// Core data-bus view of the UART transmit peripheral.
// Store semantics: WriteEn is a single-cycle strobe qualified by address;
// there is no backpressure, a store is consumed on the edge where it is seen.
// dataout and hit are combinational functions of address.
interface uart_tx_mmio_if;
  logic        WriteEn;
  logic [31:0] address;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        hit;

  modport master (output WriteEn, output address, output datain,
                  input dataout, input hit);
  modport slave  (input WriteEn, input address, input datain,
                  output dataout, output hit);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 serial transmitter: stores to TXDATA queue bytes in a
// FIFO, a shifter drains them onto tx; STATUS reports FIFO/FSM state.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          DEPTH        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_mmio_if.slave        bus,
  output logic                 tx,
  output logic [1:0]           dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [4:0]      count;
  logic            overflow;

  logic [1:0]      sel;
  logic            full;
  logic            empty;
  logic            busy;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            ovf_clr;
  logic            baud_tc;
  logic [31:0]     status;
  logic            unused_bits;

  // Address decode and request qualification; full/empty are pre-edge values.
  always_comb begin
    bus.hit  = (bus.address[31:4] == BASE_ADDR[31:4]);
    sel      = bus.address[3:2];
    full     = (count == 5'(DEPTH));
    empty    = (count == 5'd0);
    busy     = (state != IDLE);
    push_req = bus.WriteEn & bus.hit & (sel == 2'd0);
    push     = push_req & ~full;
    pop      = (state == IDLE) & ~empty;
    ovf_clr  = bus.WriteEn & bus.hit & (sel == 2'd1) & bus.datain[3];
    baud_tc  = (baud == BW'(CLKS_PER_BIT - 1));
    status   = {19'd0, count, 4'd0, overflow, busy, empty, full};
    bus.dataout = 32'd0;
    if (bus.hit && sel == 2'd1) bus.dataout = status;
  end

  // Byte lane above [7:0] and the byte offset within a word carry no meaning here.
  assign unused_bits = ^{bus.datain[31:8], bus.address[1:0]};

  // FIFO storage; pointers are reset elsewhere so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= bus.datain[7:0];
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (push_req && full) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

  // Transmit FSM; tx is a flop fed from the current state, one cycle behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        default: tx <= 1'b1;
      endcase
      case (state)
        IDLE: begin
          if (!empty) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          if (baud_tc) begin
            baud    <= '0;
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud  <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          if (baud_tc) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: bus stores/loads driven on negedge, tx decoded by a
// frame receiver and compared against an expected byte queue.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          C     = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] STAT  = BASE + 32'h4;
  localparam int          RX_TIMEOUT = 200;

  logic       clk;
  logic       reset;
  logic       tx;
  logic [1:0] dbg_state;
  int         cyc;
  int         checks;
  int         failures;
  logic [7:0] exp_q[$];

  uart_tx_mmio_if bus_if ();

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .tx        (tx),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // STATUS word built from its field definitions.
  function automatic logic [31:0] status_word(input bit f, input bit e, input bit b,
                                              input bit o, input int cnt);
    logic [31:0] w;
    w = 32'd0;
    w[0] = f; w[1] = e; w[2] = b; w[3] = o;
    w[12:8] = cnt[4:0];
    return w;
  endfunction

  // Driver tasks.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.WriteEn = 1'b1;
    bus_if.address = a;
    bus_if.datain  = d;
  endtask

  task automatic read_status(output logic [31:0] v);
    logic [31:0] r;
    r = $urandom();
    @(negedge clk);
    bus_if.WriteEn = 1'b0;
    bus_if.address = STAT | {30'd0, r[1:0]};
    bus_if.datain  = r;
    #1 v = bus_if.dataout;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      bus_if.WriteEn = 1'b0;
      bus_if.address = STAT;
      #1;
      if (bus_if.dataout === 32'h2 && tx === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s wait_idle: status=%h tx=%b required status=00000002 tx=1", tag, bus_if.dataout, tx);
    end
  endtask

  // Receiver: find a start bit, sample each bit in its middle.
  task automatic rx_byte(output logic [7:0] b, output int s0, output bit ok, output logic stop);
    ok = 1'b0; b = 8'd0; s0 = 0; stop = 1'b0;
    for (int t = 0; t < RX_TIMEOUT; t++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    s0 = cyc;
    repeat (C + C / 2) @(negedge clk);
    b[0] = tx;
    for (int i = 1; i < 8; i++) begin
      repeat (C) @(negedge clk);
      b[i] = tx;
    end
    repeat (C) @(negedge clk);
    stop = tx;
  endtask

  // Scoreboard: n frames against exp_q, with exact back-to-back spacing.
  task automatic rx_check(input int n, input string tag);
    logic [7:0] b;
    logic [7:0] e;
    logic       stop;
    int         s0;
    int         prev;
    bit         ok;
    prev = 0;
    for (int k = 0; k < n; k++) begin
      rx_byte(b, s0, ok, stop);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL %s rx_start frame=%0d: no start bit within %0d cycles", tag, k, RX_TIMEOUT);
        return;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (b !== e) begin
        failures++;
        $display("FAIL %s rx_data frame=%0d: got %h required %h", tag, k, b, e);
      end
      checks++;
      if (stop !== 1'b1) begin
        failures++;
        $display("FAIL %s rx_stop frame=%0d: got %b required 1", tag, k, stop);
      end
      if (k > 0) begin
        checks++;
        if (s0 - prev != 10 * C + 1) begin
          failures++;
          $display("FAIL %s frame_spacing frame=%0d: got %0d required %0d", tag, k, s0 - prev, 10 * C + 1);
        end
      end
      prev = s0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.WriteEn = 1'b0; bus_if.address = 32'd0; bus_if.datain = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_if.address = STAT;
    #1;
    checks++;
    if (bus_if.hit !== 1'b1) begin
      failures++; $display("FAIL reset_hit: got %b required 1", bus_if.hit);
    end
    checks++;
    if (bus_if.dataout !== 32'h2) begin
      failures++; $display("FAIL reset_status: got %h required 00000002", bus_if.dataout);
    end
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL reset_tx: got %b required 1", tx);
    end
  endtask

  // Exact waveform of one frame plus busy, sampled each cycle after the write edge.
  task automatic test_frame_timing();
    logic [7:0]  byte_v;
    logic        etx;
    int          k;
    wait_idle("frame_timing");
    byte_v = 8'hA5;
    store(BASE, 32'h1234_56A5);
    for (int j = 0; j < 48; j++) begin
      @(negedge clk);
      bus_if.WriteEn = 1'b0;
      bus_if.address = STAT;
      #1;
      if (j < 2 || j >= 2 + 10 * C) etx = 1'b1;
      else begin
        k = (j - 2) / C;
        etx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : byte_v[k - 1];
      end
      checks++;
      if (tx !== etx) begin
        failures++; $display("FAIL frame_tx j=%0d: got %b required %b", j, tx, etx);
      end
      checks++;
      if (j == 0) begin
        if (bus_if.dataout !== status_word(0, 0, 0, 0, 1)) begin
          failures++; $display("FAIL frame_status0: got %h required %h", bus_if.dataout, status_word(0, 0, 0, 0, 1));
        end
      end else if (j <= 10 * C) begin
        if (bus_if.dataout !== status_word(0, 1, 1, 0, 0)) begin
          failures++; $display("FAIL frame_busy j=%0d: got %h required %h", j, bus_if.dataout, status_word(0, 1, 1, 0, 0));
        end
      end else begin
        if (bus_if.dataout !== 32'h2) begin
          failures++; $display("FAIL frame_after j=%0d: got %h required 00000002", j, bus_if.dataout);
        end
      end
    end
  endtask

  // Fill to full, overflow on the extra store, W1C behaviour, ordered drain.
  task automatic test_fill_overflow();
    logic [31:0] v;
    logic [31:0] r;
    wait_idle("fill");
    for (int i = 1; i <= 9; i++) exp_q.push_back(8'(i));
    fork
      begin
        for (int i = 1; i <= 9; i++) begin
          r = $urandom();
          store(BASE, {r[31:8], 8'(i)});
        end
        read_status(v);
        checks++;
        if (v !== status_word(1, 0, 1, 0, 8)) begin
          failures++; $display("FAIL fill_full: got %h required %h", v, status_word(1, 0, 1, 0, 8));
        end
        store(BASE, 32'h0000_000A);
        read_status(v);
        checks++;
        if (v !== status_word(1, 0, 1, 1, 8)) begin
          failures++; $display("FAIL fill_overflow: got %h required %h", v, status_word(1, 0, 1, 1, 8));
        end
        r = $urandom();
        store(STAT, r & ~32'h8);
        read_status(v);
        checks++;
        if (v !== status_word(1, 0, 1, 1, 8)) begin
          failures++; $display("FAIL w1c_zero: got %h required %h", v, status_word(1, 0, 1, 1, 8));
        end
        r = $urandom();
        store(STAT, r | 32'h8);
        read_status(v);
        checks++;
        if (v !== status_word(1, 0, 1, 0, 8)) begin
          failures++; $display("FAIL w1c_clear: got %h required %h", v, status_word(1, 0, 1, 0, 8));
        end
      end
      rx_check(9, "fill");
    join
    wait_idle("fill_drain");
  endtask

  // Accesses outside the window, and unused offsets inside it.
  task automatic test_miss();
    int tx_bad;
    wait_idle("miss");
    store(BASE + 32'h10, 32'h0000_0055);
    #1;
    checks++;
    if (bus_if.hit !== 1'b0 || bus_if.dataout !== 32'd0) begin
      failures++; $display("FAIL miss_window: hit=%b dataout=%h required hit=0 dataout=0", bus_if.hit, bus_if.dataout);
    end
    store(32'h0000_1000, 32'h0000_0066);
    #1;
    checks++;
    if (bus_if.hit !== 1'b0 || bus_if.dataout !== 32'd0) begin
      failures++; $display("FAIL miss_datamem: hit=%b dataout=%h required hit=0 dataout=0", bus_if.hit, bus_if.dataout);
    end
    store(BASE + 32'hC, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (bus_if.hit !== 1'b1 || bus_if.dataout !== 32'd0) begin
      failures++; $display("FAIL off_c: hit=%b dataout=%h required hit=1 dataout=0", bus_if.hit, bus_if.dataout);
    end
    store(BASE + 32'h8, 32'h0000_0077);
    #1;
    checks++;
    if (bus_if.dataout !== 32'd0) begin
      failures++; $display("FAIL off_8: dataout=%h required 0", bus_if.dataout);
    end
    tx_bad = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      bus_if.WriteEn = 1'b0;
      bus_if.address = BASE;
      #1;
      if (tx !== 1'b1) tx_bad++;
      checks++;
      if (bus_if.dataout !== 32'd0) begin
        failures++; $display("FAIL txdata_read j=%0d: got %h required 0", j, bus_if.dataout);
      end
    end
    checks++;
    if (tx_bad != 0) begin
      failures++; $display("FAIL miss_tx: %0d low samples required 0", tx_bad);
    end
    bus_if.address = BASE + 32'h7;
    #1;
    checks++;
    if (bus_if.dataout !== 32'h2) begin
      failures++; $display("FAIL miss_count: status=%h required 00000002", bus_if.dataout);
    end
  endtask

  // Reset during a data bit with three bytes still queued.
  task automatic test_reset_mid();
    logic [31:0] r;
    int          tx_bad;
    int          st_bad;
    wait_idle("reset_mid");
    for (int i = 0; i < 4; i++) begin
      r = $urandom();
      store(BASE, r);
    end
    @(negedge clk);
    bus_if.WriteEn = 1'b0;
    repeat (2 * C) @(negedge clk);
    r = $urandom();
    reset = 1'b1;
    bus_if.WriteEn = 1'b1;
    bus_if.address = BASE;
    bus_if.datain  = r;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL reset_mid_tx: got %b required 1", tx);
    end
    bus_if.WriteEn = 1'b0;
    bus_if.address = STAT;
    #1;
    checks++;
    if (bus_if.dataout !== 32'h2) begin
      failures++; $display("FAIL reset_mid_status: got %h required 00000002", bus_if.dataout);
    end
    @(negedge clk);
    reset = 1'b0;
    tx_bad = 0; st_bad = 0;
    for (int j = 0; j < 15 * C; j++) begin
      @(negedge clk);
      #1;
      if (tx !== 1'b1) tx_bad++;
      if (bus_if.dataout !== 32'h2) st_bad++;
    end
    checks++;
    if (tx_bad != 0 || st_bad != 0) begin
      failures++; $display("FAIL reset_mid_quiet: tx_low=%0d status_bad=%0d required 0 0", tx_bad, st_bad);
    end
  endtask

  // Random bursts (never more than fit) with random gaps and address low bits.
  task automatic test_back_to_back();
    int          n;
    logic [31:0] r;
    logic [7:0]  b;
    for (int round = 0; round < 4; round++) begin
      wait_idle("b2b");
      n = $urandom_range(1, DEPTH + 1);
      fork
        begin
          for (int k = 0; k < n; k++) begin
            r = $urandom();
            b = r[7:0];
            exp_q.push_back(b);
            store(BASE | {30'd0, r[9:8]}, r);
            if (r[10]) begin
              @(negedge clk);
              bus_if.WriteEn = 1'b0;
            end
          end
          @(negedge clk);
          bus_if.WriteEn = 1'b0;
        end
        rx_check(n, "b2b");
      join
      wait_idle("b2b_end");
    end
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    failures = 0;
    test_reset();
    test_frame_timing();
    test_fill_overflow();
    test_miss();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
